// File: rtl/vend_pkg.sv
// Shared types and coin arithmetic for the vending-machine controller.
package vend_pkg;

  typedef enum logic [2:0] {
    COIN_5C   = 3'd0,
    COIN_10C  = 3'd1,
    COIN_25C  = 3'd2,
    COIN_50C  = 3'd3,
    COIN_100C = 3'd4,
    COIN_500C = 3'd5
  } coin_type_e;

  typedef enum logic [1:0] {
    CHG_5C  = 2'd0,
    CHG_10C = 2'd1,
    CHG_25C = 2'd2
  } chg_coin_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_e;

  localparam int unsigned CENTS_5  = 5;
  localparam int unsigned CENTS_10 = 10;
  localparam int unsigned CENTS_25 = 25;

  // Invalid coin types map to 0 cents, which callers treat as "reject".
  function automatic int unsigned coin_value(input logic [2:0] coinType);
    case (coinType)
      COIN_5C:   return 5;
      COIN_10C:  return 10;
      COIN_25C:  return 25;
      COIN_50C:  return 50;
      COIN_100C: return 100;
      COIN_500C: return 500;
      default:   return 0;
    endcase
  endfunction

  function automatic int unsigned chgValue(input logic [1:0] chgCoin);
    case (chgCoin)
      CHG_25C: return CENTS_25;
      CHG_10C: return CENTS_10;
      default: return CENTS_5;
    endcase
  endfunction

  function automatic logic [1:0] pickChg(input int unsigned amount);
    if (amount >= CENTS_25)      return CHG_25C;
    else if (amount >= CENTS_10) return CHG_10C;
    else                         return CHG_5C;
  endfunction

endpackage

// File: rtl/vend_change_disp.sv
// Greedy 25/10/5 change emitter: loaded with an amount, offers one coin at a time.
module vend_change_disp
  import vend_pkg::*;
#(
  parameter int unsigned CENTS_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [CENTS_W-1:0] amount,
  output logic               chgValid,
  output logic [1:0]         chgCoin,
  input  logic               chgReady,
  output logic               done
);

  logic [CENTS_W-1:0] remaining;
  logic [CENTS_W-1:0] remNext;
  logic [CENTS_W-1:0] coinCents;
  logic               xfer;

  always_comb begin
    coinCents = CENTS_W'(chgValue(chgCoin));
    xfer      = chgValid && chgReady;
    remNext   = remaining;
    if (load)
      remNext = amount;
    else if (xfer)
      remNext = remaining - coinCents;
  end

  assign done = xfer && (remaining == coinCents);

  // Offered coin is registered from the next remainder so it never changes while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      chgValid  <= 1'b0;
      chgCoin   <= '0;
    end else begin
      remaining <= remNext;
      chgValid  <= (remNext != '0);
      chgCoin   <= pickChg(32'(remNext));
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine controller: credit, price/stock table, vend handshake and change.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 9,
  parameter int unsigned CENTS_W    = 10,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned MAX_CREDIT = 500
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         coin_valid,
  input  logic [2:0]                   coin_type,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_SLOTS)-1:0] sel_idx,
  input  logic                         cancel,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_idx,
  input  logic [CENTS_W-1:0]           cfg_price,
  input  logic [STOCK_W-1:0]           cfg_stock,
  output logic                         vend_req,
  output logic [$clog2(NUM_SLOTS)-1:0] vend_idx,
  input  logic                         vend_ack,
  output logic                         chg_valid,
  output logic [1:0]                   chg_coin,
  input  logic                         chg_ready,
  output logic                         rej_valid,
  output logic [2:0]                   rej_coin,
  output logic [CENTS_W-1:0]           credit,
  output logic [CENTS_W-1:0]           disp_value,
  output logic [NUM_SLOTS-1:0]         avail,
  output logic [NUM_SLOTS-1:0]         soldout,
  output logic                         busy
);

  localparam int unsigned IDX_W = $clog2(NUM_SLOTS);

  state_e             state, stateNext;
  logic [CENTS_W-1:0] price [NUM_SLOTS];
  logic [STOCK_W-1:0] stock [NUM_SLOTS];

  logic [CENTS_W-1:0] creditNext, dispNext, remainder, chgCents;
  logic [IDX_W-1:0]   vendIdxNext;
  logic [2:0]         rejCoinNext;
  logic               rejValidNext;
  logic               cfgWrite, stockDec, chgLoad, chgXfer, chgDone;
  logic               coinTaken, coinOk, selInRange, cfgInRange;
  int unsigned        coinCents;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      soldout[i] = (price[i] == '0) || (stock[i] == '0);
      avail[i]   = (price[i] != '0) && (stock[i] != '0) && (credit >= price[i]);
    end
  end

  assign vend_req = (state == VEND);
  assign busy     = (state != IDLE);
  assign chgXfer  = chg_valid && chg_ready;
  assign chgCents = CENTS_W'(chgValue(chg_coin));

  always_comb begin
    stateNext    = state;
    creditNext   = credit;
    dispNext     = disp_value;
    vendIdxNext  = vend_idx;
    rejValidNext = 1'b0;
    rejCoinNext  = rej_coin;
    cfgWrite     = 1'b0;
    stockDec     = 1'b0;
    chgLoad      = 1'b0;
    coinTaken    = 1'b0;
    remainder    = credit - price[vend_idx];
    coinCents    = coin_value(coin_type);
    coinOk       = (coinCents != 0) && ((32'(credit) + coinCents) <= MAX_CREDIT);
    selInRange   = 32'(sel_idx) < NUM_SLOTS;
    cfgInRange   = 32'(cfg_idx) < NUM_SLOTS;

    case (state)
      IDLE: begin
        if (cancel && credit != '0) begin
          stateNext = CHANGE;
          chgLoad   = 1'b1;
          dispNext  = credit;
        end else if (sel_valid && selInRange) begin
          if (credit != '0 && avail[sel_idx]) begin
            vendIdxNext = sel_idx;
            stateNext   = VEND;
          end else begin
            dispNext = price[sel_idx];
          end
        end else if (coin_valid) begin
          if (coinOk) begin
            coinTaken  = 1'b1;
            creditNext = CENTS_W'(32'(credit) + coinCents);
            dispNext   = CENTS_W'(32'(credit) + coinCents);
          end
        end else if (cfg_we && !cancel && !sel_valid && cfgInRange) begin
          cfgWrite = 1'b1;
        end
      end
      VEND: begin
        if (vend_ack) begin
          stockDec   = 1'b1;
          creditNext = remainder;
          dispNext   = remainder;
          if (remainder != '0) begin
            stateNext = CHANGE;
            chgLoad   = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      CHANGE: begin
        if (chgXfer) begin
          creditNext = credit - chgCents;
          dispNext   = credit - chgCents;
          if (chgDone)
            stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    // Any coin not credited in this cycle goes straight back out.
    if (coin_valid && !coinTaken) begin
      rejValidNext = 1'b1;
      rejCoinNext  = coin_type;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      credit     <= '0;
      disp_value <= '0;
      vend_idx   <= '0;
      rej_valid  <= 1'b0;
      rej_coin   <= '0;
    end else begin
      state      <= stateNext;
      credit     <= creditNext;
      disp_value <= dispNext;
      vend_idx   <= vendIdxNext;
      rej_valid  <= rejValidNext;
      rej_coin   <= rejCoinNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        price[i] <= '0;
        stock[i] <= '0;
      end
    end else if (cfgWrite) begin
      price[cfg_idx] <= cfg_price;
      stock[cfg_idx] <= cfg_stock;
    end else if (stockDec) begin
      stock[vend_idx] <= stock[vend_idx] - STOCK_W'(1);
    end
  end

  vend_change_disp #(.CENTS_W(CENTS_W)) uChange (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (chgLoad),
    .amount   (creditNext),
    .chgValid (chg_valid),
    .chgCoin  (chg_coin),
    .chgReady (chg_ready),
    .done     (chgDone)
  );

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed vector table, corner sequences, random run against a model.
module tb_vend_ctrl;

  localparam int NS = 9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid, sel_valid, cancel, cfg_we, vend_ack, chg_ready;
  logic [2:0] coin_type;
  logic [3:0] sel_idx, cfg_idx, cfg_stock, vend_idx;
  logic [9:0] cfg_price, credit, disp_value;
  logic       vend_req, chg_valid, rej_valid, busy;
  logic [1:0] chg_coin;
  logic [2:0] rej_coin;
  logic [8:0] avail, soldout;

  always #5 clk = ~clk;

  vend_ctrl #(.NUM_SLOTS(9), .CENTS_W(10), .STOCK_W(4), .MAX_CREDIT(500)) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_type(coin_type),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_price(cfg_price), .cfg_stock(cfg_stock),
    .vend_req(vend_req), .vend_idx(vend_idx), .vend_ack(vend_ack),
    .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ready(chg_ready),
    .rej_valid(rej_valid), .rej_coin(rej_coin), .credit(credit),
    .disp_value(disp_value), .avail(avail), .soldout(soldout), .busy(busy)
  );

  typedef struct {
    bit coinV; bit [2:0] coinT; bit selV; bit [3:0] selI; bit cancel;
    bit cfgWe; bit [3:0] cfgI; bit [9:0] cfgP; bit [3:0] cfgS; bit ack; bit ready;
  } in_t;

  typedef struct {
    bit rst; in_t in; int credit; int disp; bit vreq; bit cv; int cc; bit rv; int rc; int so;
  } vec_t;

  int nTests = 0;
  int nFail  = 0;
  vec_t vecs[$];

  function automatic void chk(string name, int act, int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic in_t inNone();
    in_t v;
    v = '{default: '0};
    return v;
  endfunction
  function automatic in_t inCoin(int t);
    in_t v = inNone(); v.coinV = 1; v.coinT = 3'(t); return v;
  endfunction
  function automatic in_t inSel(int i);
    in_t v = inNone(); v.selV = 1; v.selI = 4'(i); return v;
  endfunction
  function automatic in_t inCfg(int i, int p, int s);
    in_t v = inNone(); v.cfgWe = 1; v.cfgI = 4'(i); v.cfgP = 10'(p); v.cfgS = 4'(s); return v;
  endfunction
  function automatic in_t inAck();
    in_t v = inNone(); v.ack = 1; return v;
  endfunction
  function automatic in_t inRdy();
    in_t v = inNone(); v.ready = 1; return v;
  endfunction
  function automatic in_t inCancelCoin(int t);
    in_t v = inCoin(t); v.cancel = 1; return v;
  endfunction

  function automatic void setIn(in_t v);
    coin_valid = v.coinV; coin_type = v.coinT; sel_valid = v.selV; sel_idx = v.selI;
    cancel = v.cancel; cfg_we = v.cfgWe; cfg_idx = v.cfgI; cfg_price = v.cfgP;
    cfg_stock = v.cfgS; vend_ack = v.ack; chg_ready = v.ready;
  endfunction

  function automatic void addV(bit rst, in_t in, int cr, int dp, bit vr, bit cv, int cc,
                               bit rv, int rc, int so);
    vec_t t;
    t.rst = rst; t.in = in; t.credit = cr; t.disp = dp; t.vreq = vr; t.cv = cv;
    t.cc = cc; t.rv = rv; t.rc = rc; t.so = so;
    vecs.push_back(t);
  endfunction

  // ---------------- reference model ----------------
  int mCredit, mDisp, mVidx, mRejC;
  int mPrice[NS], mStock[NS];
  bit mVending, mRejV;
  int mQ[$];

  function automatic void mReset();
    mCredit = 0; mDisp = 0; mVidx = 0; mRejC = 0; mVending = 0; mRejV = 0;
    mQ.delete();
    for (int i = 0; i < NS; i++) begin mPrice[i] = 0; mStock[i] = 0; end
  endfunction

  function automatic int cents(int t);
    case (t)
      0: return 5;   1: return 10;  2: return 25;
      3: return 50;  4: return 100; 5: return 500;
      default: return 0;
    endcase
  endfunction

  function automatic void mRefund();
    int amt = mCredit;
    while (amt > 0) begin
      int c = (amt >= 25) ? 25 : (amt >= 10) ? 10 : 5;
      mQ.push_back(c);
      amt -= c;
    end
  endfunction

  function automatic bit mAvail(int i);
    return mPrice[i] != 0 && mStock[i] != 0 && mCredit >= mPrice[i];
  endfunction

  function automatic void mStep(in_t v);
    bit used = 0;
    mRejV = 0;
    if (mVending) begin
      if (v.ack) begin
        mStock[mVidx]--;
        mCredit -= mPrice[mVidx];
        mVending = 0;
        mDisp = mCredit;
        if (mCredit > 0) mRefund();
      end
    end else if (mQ.size() > 0) begin
      if (v.ready) begin
        mCredit -= mQ.pop_front();
        mDisp = mCredit;
      end
    end else if (v.cancel && mCredit > 0) begin
      mDisp = mCredit;
      mRefund();
    end else if (v.selV && v.selI < NS) begin
      if (mCredit > 0 && mAvail(v.selI)) begin
        mVending = 1; mVidx = v.selI;
      end else begin
        mDisp = mPrice[v.selI];
      end
    end else if (v.coinV) begin
      if (cents(v.coinT) != 0 && mCredit + cents(v.coinT) <= 500) begin
        mCredit += cents(v.coinT); mDisp = mCredit; used = 1;
      end
    end else if (v.cfgWe && v.cfgI < NS) begin
      mPrice[v.cfgI] = v.cfgP; mStock[v.cfgI] = v.cfgS;
    end
    if (v.coinV && !used) begin mRejV = 1; mRejC = v.coinT; end
  endfunction

  function automatic void cmpModel(int n);
    int exAv = 0, exSo = 0, head;
    for (int i = 0; i < NS; i++) begin
      if (mPrice[i] == 0 || mStock[i] == 0) exSo |= (1 << i);
      if (mAvail(i)) exAv |= (1 << i);
    end
    chk($sformatf("r%0d.credit", n), int'(credit), mCredit);
    chk($sformatf("r%0d.disp", n), int'(disp_value), mDisp);
    chk($sformatf("r%0d.vreq", n), int'(vend_req), int'(mVending));
    if (mVending) chk($sformatf("r%0d.vidx", n), int'(vend_idx), mVidx);
    chk($sformatf("r%0d.cvalid", n), int'(chg_valid), int'(mQ.size() > 0));
    if (mQ.size() > 0) begin
      head = mQ[0];
      chk($sformatf("r%0d.ccoin", n), int'(chg_coin), (head == 25) ? 2 : (head == 10) ? 1 : 0);
    end
    chk($sformatf("r%0d.rvalid", n), int'(rej_valid), int'(mRejV));
    if (mRejV) chk($sformatf("r%0d.rcoin", n), int'(rej_coin), mRejC);
    chk($sformatf("r%0d.avail", n), int'(avail), exAv);
    chk($sformatf("r%0d.soldout", n), int'(soldout), exSo);
    chk($sformatf("r%0d.busy", n), int'(busy), int'(mVending || mQ.size() > 0));
  endfunction

  function automatic in_t randIn();
    in_t v = inNone();
    int r = $urandom_range(0, 99);
    if (r < 6) v.cancel = 1;
    else if (r < 20) begin v.selV = 1; v.selI = 4'($urandom_range(0, 10)); end
    else if (r < 32) begin
      v.cfgWe = 1; v.cfgI = 4'($urandom_range(0, 10));
      v.cfgP = 10'($urandom_range(0, 30) * 5); v.cfgS = 4'($urandom_range(0, 3));
    end
    if ($urandom_range(0, 99) < 35) begin v.coinV = 1; v.coinT = 3'($urandom_range(0, 7)); end
    // Keep coin-with-ineffective-cancel/selection combinations out of the random mix.
    if (v.cancel && mCredit == 0) v.coinV = 0;
    if (v.selV && v.selI >= NS) v.coinV = 0;
    v.ack   = ($urandom_range(0, 99) < 40);
    v.ready = ($urandom_range(0, 99) < 60);
    return v;
  endfunction

  task automatic apply(input in_t v);
    setIn(v);
    @(posedge clk); #1;
    setIn(inNone());
  endtask

  task automatic doReset();
    setIn(inNone());
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    mReset();
  endtask

  initial begin
    in_t nop = inNone();

    // rst, input, credit, disp, vreq, cvalid, ccoin, rvalid, rcoin, soldout
    addV(1, inCfg(9, 5, 1),   0,   0,   0, 0, 0, 0, 0, 'h1FF);
    addV(0, inCfg(0, 100, 2), 0,   0,   0, 0, 0, 0, 0, 'h1FE);
    addV(0, inCoin(4),        100, 100, 0, 0, 0, 0, 0, 'h1FE);
    addV(0, inSel(0),         100, 100, 1, 0, 0, 0, 0, 'h1FE);
    addV(0, inAck(),          0,   0,   0, 0, 0, 0, 0, 'h1FE);
    for (int k = 1; k <= 4; k++) addV(0, inCoin(4), 100 * k, 100 * k, 0, 0, 0, 0, 0, 'h1FE);
    addV(0, inCoin(3),        450, 450, 0, 0, 0, 0, 0, 'h1FE);
    addV(0, inCoin(4),        450, 450, 0, 0, 0, 1, 4, 'h1FE);
    addV(0, inCoin(3),        500, 500, 0, 0, 0, 0, 0, 'h1FE);
    addV(0, inCoin(5),        500, 500, 0, 0, 0, 1, 5, 'h1FE);
    addV(1, inCfg(3, 65, 1),  0,   0,   0, 0, 0, 0, 0, 'h1F7);
    addV(0, inCoin(4),        100, 100, 0, 0, 0, 0, 0, 'h1F7);
    addV(0, inSel(3),         100, 100, 1, 0, 0, 0, 0, 'h1F7);
    addV(0, inAck(),          35,  35,  0, 1, 2, 0, 0, 'h1FF);
    addV(0, inRdy(),          10,  10,  0, 1, 1, 0, 0, 'h1FF);
    addV(0, inRdy(),          0,   0,   0, 0, 0, 0, 0, 'h1FF);
    addV(0, inSel(3),         0,   65,  0, 0, 0, 0, 0, 'h1FF);
    addV(0, inCoin(4),        100, 100, 0, 0, 0, 0, 0, 'h1FF);
    addV(0, inSel(3),         100, 65,  0, 0, 0, 0, 0, 'h1FF);
    addV(0, inCfg(3, 65, 2),  100, 65,  0, 0, 0, 0, 0, 'h1F7);
    addV(0, inCancelCoin(0),  100, 100, 0, 1, 2, 1, 0, 'h1F7);
    addV(0, inRdy(),          75,  75,  0, 1, 2, 0, 0, 'h1F7);
    addV(0, inRdy(),          50,  50,  0, 1, 2, 0, 0, 'h1F7);
    addV(0, inRdy(),          25,  25,  0, 1, 2, 0, 0, 'h1F7);
    addV(0, inRdy(),          0,   0,   0, 0, 0, 0, 0, 'h1F7);
    addV(1, inCoin(6),        0,   0,   0, 0, 0, 1, 6, 'h1FF);
    addV(0, inCoin(2),        25,  25,  0, 0, 0, 0, 0, 'h1FF);
    addV(0, inCoin(1),        35,  35,  0, 0, 0, 0, 0, 'h1FF);
    addV(0, inCoin(0),        40,  40,  0, 0, 0, 0, 0, 'h1FF);
    addV(0, inCancelCoin(1),  40,  40,  0, 1, 2, 1, 1, 'h1FF);
    addV(0, inRdy(),          15,  15,  0, 1, 1, 0, 0, 'h1FF);
    addV(0, inRdy(),          5,   5,   0, 1, 0, 0, 0, 'h1FF);
    addV(0, inRdy(),          0,   0,   0, 0, 0, 0, 0, 'h1FF);

    setIn(nop);
    rst_n = 0;
    #2;
    chk("rst.credit", int'(credit), 0);
    chk("rst.disp", int'(disp_value), 0);
    chk("rst.outs", int'({vend_req, chg_valid, rej_valid, busy}), 0);
    chk("rst.avail", int'(avail), 0);
    chk("rst.soldout", int'(soldout), 'h1FF);
    @(posedge clk); #1;
    rst_n = 1;

    foreach (vecs[k]) begin
      if (vecs[k].rst) doReset();
      apply(vecs[k].in);
      chk($sformatf("v%0d.credit", k), int'(credit), vecs[k].credit);
      chk($sformatf("v%0d.disp", k), int'(disp_value), vecs[k].disp);
      chk($sformatf("v%0d.vreq", k), int'(vend_req), int'(vecs[k].vreq));
      chk($sformatf("v%0d.cvalid", k), int'(chg_valid), int'(vecs[k].cv));
      if (vecs[k].cv) chk($sformatf("v%0d.ccoin", k), int'(chg_coin), vecs[k].cc);
      chk($sformatf("v%0d.rvalid", k), int'(rej_valid), int'(vecs[k].rv));
      if (vecs[k].rv) chk($sformatf("v%0d.rcoin", k), int'(rej_coin), vecs[k].rc);
      chk($sformatf("v%0d.soldout", k), int'(soldout), vecs[k].so);
    end

    // Hopper stall: offered coin must hold while chg_ready is low; coins meanwhile bounce.
    doReset();
    apply(inCfg(3, 65, 1));
    apply(inCoin(4));
    apply(inSel(3));
    apply(inAck());
    for (int k = 0; k < 5; k++) begin
      apply((k == 2) ? inCoin(0) : nop);
      chk($sformatf("stall%0d.cvalid", k), int'(chg_valid), 1);
      chk($sformatf("stall%0d.ccoin", k), int'(chg_coin), 2);
      chk($sformatf("stall%0d.credit", k), int'(credit), 35);
      chk($sformatf("stall%0d.rvalid", k), int'(rej_valid), (k == 2) ? 1 : 0);
    end
    apply(inRdy());
    chk("stall.next", int'(chg_coin), 1);
    chk("stall.credit", int'(credit), 10);
    apply(inRdy());
    chk("stall.done", int'({busy, chg_valid}), 0);

    // Reset while waiting for the motor.
    doReset();
    apply(inCfg(0, 100, 2));
    apply(inCoin(4));
    apply(inSel(0));
    for (int k = 0; k < 3; k++) begin
      apply(nop);
      chk($sformatf("wait%0d.vreq", k), int'(vend_req), 1);
      chk($sformatf("wait%0d.busy", k), int'(busy), 1);
    end
    rst_n = 0;
    #1;
    chk("abort.outs", int'({vend_req, chg_valid, rej_valid, busy}), 0);
    chk("abort.credit", int'(credit), 0);
    chk("abort.disp", int'(disp_value), 0);
    chk("abort.soldout", int'(soldout), 'h1FF);
    @(posedge clk); #1;
    rst_n = 1;

    doReset();
    for (int n = 0; n < 2500; n++) begin
      in_t v = randIn();
      apply(v);
      mStep(v);
      cmpModel(n);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
